commit_unit_nw: RTL and testbench
=================================

Name: commit_unit_nw

Overview:
- Parametrised N-wide in-order commit unit for the out-of-order core, sitting between the ROB head and the architectural state (ARF/ARAT, speculative RAT checkpoint srat_1, store buffer).
- Each cycle it selects the longest retirable prefix of the ROB head window and generates per-slot write enables.
- It advances the ROB head pointer and runs a flush/recover FSM on a mispredicted branch.
- Supersedes the fixed two-slot combinational write-back enable logic.

Parameters:
- COMMIT_W, 2, commit slots per cycle (1..4)
- RN_W, 2, rename slots checked for srat_1 conflicts
- ROB_DEPTH, 16, ROB entries (power of two)
- LREG_W, 5, logical register index width
- PREG_W, 6, physical register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hd_valid  in  COMMIT_W  head-window slot i holds a valid, completed entry
- hd_rd_en  in  COMMIT_W  slot i has a destination register
- hd_rdl  in  COMMIT_W*LREG_W  slot i logical destination
- hd_rdp  in  COMMIT_W*PREG_W  slot i physical destination
- hd_rdps  in  COMMIT_W*PREG_W  current speculative mapping of hd_rdl[i]
- hd_memwen  in  COMMIT_W  slot i is a store
- hd_mispred  in  COMMIT_W  slot i is a branch with wrong prediction
- rn_rd_en  in  RN_W  rename slot j destination valid
- rn_rdl  in  RN_W*LREG_W  rename slot j logical destination
- sb_ready  in  1  store buffer can accept one commit this cycle
- retire_mask  out  COMMIT_W  registered: slot i retired
- retire_cnt  out  $clog2(COMMIT_W+1)  registered popcount of retire_mask
- rob_head  out  $clog2(ROB_DEPTH)  ROB head pointer
- arf_we  out  COMMIT_W  ARF/ARAT write enable per slot
- srat1_en  out  COMMIT_W  srat_1 update enable per slot
- sb_commit  out  COMMIT_W  store buffer state-bit write per slot
- flush  out  1  one-cycle pipeline flush pulse
- arat_restore  out  1  one-cycle ARAT-to-SRAT copy pulse

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: all outputs 0, rob_head=0, FSM=RUN.
- Retire qualification (combinational, state RUN only): slot i is eligible iff hd_valid[0..i] are all 1 and no slot k<i has hd_mispred=1.
- A store at slot i needs sb_ready=1 and no eligible store at any k<i. At most one store commits per cycle.
- The first blocked slot terminates the prefix.
- The mispredicted branch itself retires. Younger slots in the group do not.
- All outputs are registered; latency is 1 cycle from inputs to enables.
- arf_we[i] = retire[i] & hd_rd_en[i].
- sb_commit[i] = retire[i] & hd_memwen[i].
- srat1_en[i] requires all of:
  - retire[i] & hd_rd_en[i];
  - hd_rdps[i]==hd_rdp[i];
  - no j with rn_rd_en[j] & rn_rdl[j]==hd_rdl[i];
  - no retiring k>i with hd_rd_en[k] & hd_rdl[k]==hd_rdl[i].
- rob_head advances by retire_cnt each cycle, modulo ROB_DEPTH (natural wrap).
- FSM:
  - RUN→FLUSH when a mispredicted branch retires; flush=1 in the next cycle.
  - FLUSH→RECOVER after 1 cycle; arat_restore=1.
  - RECOVER→RUN after 1 cycle.
  - No retirement in FLUSH or RECOVER; all enables are 0 there.
- rst in any state wins: FSM returns to RUN and pulses are cleared that cycle.
- hd_valid=0 everywhere → retire_cnt=0 and rob_head holds.

Optional Feature:
- Macro: COMMIT_PERF_EN.
- When defined: adds outputs perf_retired (32b, accumulates retire_cnt) and perf_flush (32b, increments on each flush pulse). Both reset to 0 and wrap at 2^32.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package commit_pkg holds the FSM state enum (RUN, FLUSH, RECOVER) and a localparam function for the popcount width.
- Natural sub-module: commit_select, the combinational prefix/store/srat1 qualifier. The top holds the registers, head pointer, FSM and optional counters.

Test Plan:
- Full retire: COMMIT_W=2, both slots valid, no stores or mispredicts → next cycle retire_mask=2'b11, retire_cnt=2, rob_head 0→2.
- Gap: slot0 invalid, slot1 valid → retire_mask=0, rob_head unchanged.
- Two stores with sb_ready=1 → only slot0 commits (sb_commit=2'b01, retire_cnt=1).
- Two stores with sb_ready=0 → nothing retires.
- Mispredict at slot0: slot0 retires alone. Flush=1 next cycle, arat_restore=1 the cycle after, and retirement is blocked for those 2 cycles. rst asserted during FLUSH → RUN, all outputs 0.
- srat1 conflicts:
  - both slots write lreg 3 → srat1_en=2'b10;
  - rn_rdl[0]=3 with rn_rd_en[0]=1 → srat1_en=0;
  - hd_rdps≠hd_rdp → 0.
- Wrap: rob_head=15, retire 2 → rob_head=1. With COMMIT_PERF_EN, perf_retired increments by 2.

Source files
------------

// File: rtl/commit_pkg.sv
// Shared types for the N-wide commit unit: the flush/recover FSM states and
// the helper that sizes the retire-count field.
package commit_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLUSH   = 2'd1,
      RECOVER = 2'd2
   } state_e;

   // Bits needed to hold a count of 0..n retired slots.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/commit_select.sv
// Combinational retire qualifier for the ROB head window.
// Picks the longest retirable prefix and derives the per-slot ARF, srat_1 and
// store-buffer enables.
// Ports:
//   run            : FSM is in RUN; when low nothing retires
//   hd_*           : head-window slot information (slot 0 is oldest)
//   rn_rd_en/rn_rdl: rename-stage destinations that will overwrite srat_1
//   sb_ready       : store buffer can take one store this cycle
//   retire         : slot i retires
//   arf_we, srat1_en, sb_commit : per-slot enables
//   mispred_retire : a mispredicted branch is among the retiring slots
module commit_select
   import commit_pkg::*;
#(
   parameter int unsigned COMMIT_W = 2,
   parameter int unsigned RN_W     = 2,
   parameter int unsigned LREG_W   = 5,
   parameter int unsigned PREG_W   = 6
) (
   input  logic                       run,
   input  logic [COMMIT_W-1:0]        hd_valid,
   input  logic [COMMIT_W-1:0]        hd_rd_en,
   input  logic [COMMIT_W*LREG_W-1:0] hd_rdl,
   input  logic [COMMIT_W*PREG_W-1:0] hd_rdp,
   input  logic [COMMIT_W*PREG_W-1:0] hd_rdps,
   input  logic [COMMIT_W-1:0]        hd_memwen,
   input  logic [COMMIT_W-1:0]        hd_mispred,
   input  logic [RN_W-1:0]            rn_rd_en,
   input  logic [RN_W*LREG_W-1:0]     rn_rdl,
   input  logic                       sb_ready,
   output logic [COMMIT_W-1:0]        retire,
   output logic [COMMIT_W-1:0]        arf_we,
   output logic [COMMIT_W-1:0]        srat1_en,
   output logic [COMMIT_W-1:0]        sb_commit,
   output logic                       mispred_retire
);

   // Prefix walk: the first slot that cannot retire ends the group; a
   // mispredicted branch retires but ends the group behind it.
   always_comb begin
      logic stop;
      logic store_taken;
      logic keep;
      retire         = '0;
      arf_we         = '0;
      srat1_en       = '0;
      sb_commit      = '0;
      mispred_retire = 1'b0;
      stop           = !run;
      store_taken    = 1'b0;
      keep           = 1'b0;

      for (int i = 0; i < int'(COMMIT_W); i++) begin
         if (!stop) begin
            if (!hd_valid[i] || (hd_memwen[i] && (!sb_ready || store_taken))) begin
               stop = 1'b1;
            end else begin
               retire[i] = 1'b1;
               if (hd_memwen[i]) store_taken = 1'b1;
               if (hd_mispred[i]) begin
                  mispred_retire = 1'b1;
                  stop           = 1'b1;
               end
            end
         end
      end

      for (int i = 0; i < int'(COMMIT_W); i++) begin
         arf_we[i]    = retire[i] & hd_rd_en[i];
         sb_commit[i] = retire[i] & hd_memwen[i];
      end

      // srat_1 only takes a retiring mapping that is still current and that
      // neither rename nor a younger retiring slot is about to overwrite.
      for (int i = 0; i < int'(COMMIT_W); i++) begin
         keep = arf_we[i] && (hd_rdps[i*PREG_W +: PREG_W] == hd_rdp[i*PREG_W +: PREG_W]);
         for (int j = 0; j < int'(RN_W); j++) begin
            if (rn_rd_en[j] && (rn_rdl[j*LREG_W +: LREG_W] == hd_rdl[i*LREG_W +: LREG_W]))
               keep = 1'b0;
         end
         for (int k = i + 1; k < int'(COMMIT_W); k++) begin
            if (arf_we[k] && (hd_rdl[k*LREG_W +: LREG_W] == hd_rdl[i*LREG_W +: LREG_W]))
               keep = 1'b0;
         end
         srat1_en[i] = keep;
      end
   end

endmodule

// File: rtl/commit_unit_nw.sv
// N-wide in-order commit unit between the ROB head and architectural state.
// Registers the per-slot enables from commit_select, advances the ROB head
// pointer and sequences flush/recover after a mispredicted branch retires.
// Optional feature macro: COMMIT_PERF_EN adds perf_retired/perf_flush counters.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   hd_*, rn_*, sb_ready  : head window, rename destinations, store buffer ready
//   retire_mask/retire_cnt: slots retired and their count
//   rob_head              : ROB head pointer
//   arf_we/srat1_en/sb_commit : per-slot architectural update enables
//   flush/arat_restore    : one-cycle recovery pulses
//   perf_retired/perf_flush (COMMIT_PERF_EN only): 32-bit event counters
module commit_unit_nw
   import commit_pkg::*;
#(
   parameter int unsigned COMMIT_W  = 2,
   parameter int unsigned RN_W      = 2,
   parameter int unsigned ROB_DEPTH = 16,
   parameter int unsigned LREG_W    = 5,
   parameter int unsigned PREG_W    = 6
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [COMMIT_W-1:0]                  hd_valid,
   input  logic [COMMIT_W-1:0]                  hd_rd_en,
   input  logic [COMMIT_W*LREG_W-1:0]           hd_rdl,
   input  logic [COMMIT_W*PREG_W-1:0]           hd_rdp,
   input  logic [COMMIT_W*PREG_W-1:0]           hd_rdps,
   input  logic [COMMIT_W-1:0]                  hd_memwen,
   input  logic [COMMIT_W-1:0]                  hd_mispred,
   input  logic [RN_W-1:0]                      rn_rd_en,
   input  logic [RN_W*LREG_W-1:0]               rn_rdl,
   input  logic                                 sb_ready,
   output logic [COMMIT_W-1:0]                  retire_mask,
   output logic [cnt_width(COMMIT_W)-1:0]       retire_cnt,
   output logic [$clog2(ROB_DEPTH)-1:0]         rob_head,
   output logic [COMMIT_W-1:0]                  arf_we,
   output logic [COMMIT_W-1:0]                  srat1_en,
   output logic [COMMIT_W-1:0]                  sb_commit,
   output logic                                 flush,
`ifdef COMMIT_PERF_EN
   output logic [31:0]                          perf_retired,
   output logic [31:0]                          perf_flush,
`endif
   output logic                                 arat_restore
);

   localparam int unsigned CNT_W  = cnt_width(COMMIT_W);
   localparam int unsigned HEAD_W = $clog2(ROB_DEPTH);

   state_e              state_q, state_d;
   logic                flush_d, arat_d;
   logic [COMMIT_W-1:0] retire_d, arf_d, srat1_d, sb_d;
   logic                mispred_retire;
   logic [CNT_W-1:0]    cnt_d;

   commit_select #(
      .COMMIT_W (COMMIT_W),
      .RN_W     (RN_W),
      .LREG_W   (LREG_W),
      .PREG_W   (PREG_W)
   ) u_select (
      .run            (state_q == RUN),
      .hd_valid       (hd_valid),
      .hd_rd_en       (hd_rd_en),
      .hd_rdl         (hd_rdl),
      .hd_rdp         (hd_rdp),
      .hd_rdps        (hd_rdps),
      .hd_memwen      (hd_memwen),
      .hd_mispred     (hd_mispred),
      .rn_rd_en       (rn_rd_en),
      .rn_rdl         (rn_rdl),
      .sb_ready       (sb_ready),
      .retire         (retire_d),
      .arf_we         (arf_d),
      .srat1_en       (srat1_d),
      .sb_commit      (sb_d),
      .mispred_retire (mispred_retire)
   );

   // Popcount of the slots retiring this cycle.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < int'(COMMIT_W); i++) begin
         cnt_d = cnt_d + CNT_W'(retire_d[i]);
      end
   end

   // Next state and recovery pulses; each pulse coincides with its state.
   always_comb begin
      state_d = state_q;
      flush_d = 1'b0;
      arat_d  = 1'b0;
      case (state_q)
         RUN: begin
            if (mispred_retire) begin
               state_d = FLUSH;
               flush_d = 1'b1;
            end
         end
         FLUSH: begin
            state_d = RECOVER;
            arat_d  = 1'b1;
         end
         RECOVER: state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // State, output registers and head pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         retire_mask  <= '0;
         retire_cnt   <= '0;
         rob_head     <= '0;
         arf_we       <= '0;
         srat1_en     <= '0;
         sb_commit    <= '0;
         flush        <= 1'b0;
         arat_restore <= 1'b0;
      end else begin
         state_q      <= state_d;
         retire_mask  <= retire_d;
         retire_cnt   <= cnt_d;
         rob_head     <= rob_head + HEAD_W'(cnt_d);
         arf_we       <= arf_d;
         srat1_en     <= srat1_d;
         sb_commit    <= sb_d;
         flush        <= flush_d;
         arat_restore <= arat_d;
      end
   end

`ifdef COMMIT_PERF_EN
   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_retired <= '0;
         perf_flush   <= '0;
      end else begin
         perf_retired <= perf_retired + 32'(cnt_d);
         perf_flush   <= perf_flush + 32'(flush_d);
      end
   end
`endif

endmodule

// File: tb/tb_commit_unit_nw.sv
// Randomised scoreboard bench for commit_unit_nw (COMMIT_W=2, RN_W=2,
// ROB_DEPTH=16). Stimulus is driven on the falling edge; the expected
// registered response is queued and a monitor checks it after the rising edge.
module tb_commit_unit_nw;

   localparam int W  = 2;
   localparam int RN = 2;
   localparam int LW = 5;
   localparam int PW = 6;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [W-1:0]    hd_valid, hd_rd_en, hd_memwen, hd_mispred;
   logic [W*LW-1:0] hd_rdl;
   logic [W*PW-1:0] hd_rdp, hd_rdps;
   logic [RN-1:0]   rn_rd_en;
   logic [RN*LW-1:0] rn_rdl;
   logic            sb_ready;
   logic [W-1:0]    retire_mask, arf_we, srat1_en, sb_commit;
   logic [1:0]      retire_cnt;
   logic [3:0]      rob_head;
   logic            flush, arat_restore;
`ifdef COMMIT_PERF_EN
   logic [31:0]     perf_retired, perf_flush;
`endif

   commit_unit_nw #(
      .COMMIT_W(W), .RN_W(RN), .ROB_DEPTH(DEPTH), .LREG_W(LW), .PREG_W(PW)
   ) dut (
      .clk(clk), .rst(rst),
      .hd_valid(hd_valid), .hd_rd_en(hd_rd_en), .hd_rdl(hd_rdl),
      .hd_rdp(hd_rdp), .hd_rdps(hd_rdps), .hd_memwen(hd_memwen),
      .hd_mispred(hd_mispred), .rn_rd_en(rn_rd_en), .rn_rdl(rn_rdl),
      .sb_ready(sb_ready),
      .retire_mask(retire_mask), .retire_cnt(retire_cnt), .rob_head(rob_head),
      .arf_we(arf_we), .srat1_en(srat1_en), .sb_commit(sb_commit),
      .flush(flush),
`ifdef COMMIT_PERF_EN
      .perf_retired(perf_retired), .perf_flush(perf_flush),
`endif
      .arat_restore(arat_restore)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mask, cnt, head, arf, srat, sb, fl, ar;
      int unsigned pr, pf;
   } exp_t;

   exp_t q[$];
   int   total  = 0;
   int   passed = 0;

   // Reference model state: head as a plain integer, blocked-cycle countdown.
   int          m_head = 0;
   int          m_pend = 0;
   int unsigned m_pr = 0, m_pf = 0;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
   endtask

   function automatic int lreg(input logic [W*LW-1:0] v, input int i);
      return int'(v[i*LW +: LW]);
   endfunction

   // Compute the response the DUT must show after the coming rising edge.
   task automatic push_expect();
      exp_t e;
      int n;
      bit st, mp, ok;
      e = '{default: 0};
      if (rst) begin
         m_head = 0; m_pend = 0; m_pr = 0; m_pf = 0;
      end else if (m_pend > 0) begin
         if (m_pend == 2) e.ar = 1;
         m_pend--;
      end else begin
         n = 0; st = 0; mp = 0;
         for (int i = 0; i < W; i++) begin
            if (!hd_valid[i]) break;
            if (hd_memwen[i]) begin
               if (!sb_ready || st) break;
               st = 1;
            end
            n++;
            if (hd_mispred[i]) begin mp = 1; break; end
         end
         e.mask = (1 << n) - 1;
         e.cnt  = n;
         for (int i = 0; i < n; i++) begin
            if (hd_rd_en[i]) e.arf |= (1 << i);
            if (hd_memwen[i]) e.sb |= (1 << i);
            ok = hd_rd_en[i] && (hd_rdp[i*PW +: PW] == hd_rdps[i*PW +: PW]);
            for (int j = 0; j < RN; j++)
               if (rn_rd_en[j] && lreg(rn_rdl, j) == lreg(hd_rdl, i)) ok = 0;
            for (int k = i + 1; k < n; k++)
               if (hd_rd_en[k] && lreg(hd_rdl, k) == lreg(hd_rdl, i)) ok = 0;
            if (ok) e.srat |= (1 << i);
         end
         m_head = (m_head + n) % DEPTH;
         m_pr   = m_pr + n;
         if (mp) begin e.fl = 1; m_pend = 2; m_pf = m_pf + 1; end
      end
      e.head = m_head;
      e.pr = m_pr;
      e.pf = m_pf;
      q.push_back(e);
   endtask

   task automatic cyc();
      push_expect();
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; hd_valid = '0; hd_rd_en = '0; hd_rdl = '0; hd_rdp = '0;
      hd_rdps = '0; hd_memwen = '0; hd_mispred = '0; rn_rd_en = '0;
      rn_rdl = '0; sb_ready = 1'b1;
   endtask

   task automatic set_slot(input int i, input bit v, input bit rd, input int l,
                           input bit st, input bit mp);
      hd_valid[i] = v; hd_rd_en[i] = rd; hd_rdl[i*LW +: LW] = LW'(l);
      hd_memwen[i] = st; hd_mispred[i] = mp;
      hd_rdp[i*PW +: PW] = PW'(10 + i); hd_rdps[i*PW +: PW] = PW'(10 + i);
   endtask

   // Monitor: compares whenever a response is due.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("retire_mask", int'(retire_mask), e.mask);
            chk("retire_cnt", int'(retire_cnt), e.cnt);
            chk("rob_head", int'(rob_head), e.head);
            chk("arf_we", int'(arf_we), e.arf);
            chk("srat1_en", int'(srat1_en), e.srat);
            chk("sb_commit", int'(sb_commit), e.sb);
            chk("flush", int'(flush), e.fl);
            chk("arat_restore", int'(arat_restore), e.ar);
`ifdef COMMIT_PERF_EN
            chk("perf_retired", int'(perf_retired), int'(e.pr));
            chk("perf_flush", int'(perf_flush), int'(e.pf));
`endif
         end
      end
   end

   initial begin
      idle();
      rst = 1;
      @(negedge clk);
      cyc(); cyc();
      idle();
      // Full retire, then a gap at slot 0.
      set_slot(0, 1, 1, 1, 0, 0); set_slot(1, 1, 1, 2, 0, 0); cyc();
      idle(); set_slot(1, 1, 1, 2, 0, 0); cyc();
      // Two stores with and without store-buffer space.
      idle(); set_slot(0, 1, 0, 0, 1, 0); set_slot(1, 1, 0, 0, 1, 0); cyc();
      sb_ready = 0; cyc();
      // srat_1 conflicts.
      idle(); set_slot(0, 1, 1, 3, 0, 0); set_slot(1, 1, 1, 3, 0, 0); cyc();
      rn_rd_en = 2'b01; rn_rdl[0 +: LW] = 5'd3; cyc();
      idle(); set_slot(0, 1, 1, 3, 0, 0); set_slot(1, 1, 1, 4, 0, 0);
      hd_rdps[0 +: PW] = 6'd33; hd_rdps[PW +: PW] = 6'd34; cyc();
      // Mispredict at slot 0 with full window held through recovery.
      idle(); set_slot(0, 1, 1, 5, 0, 1); set_slot(1, 1, 1, 6, 0, 0); cyc();
      hd_mispred = '0; cyc(); cyc(); cyc();
      // Mispredict then reset during FLUSH.
      hd_mispred = 2'b01; cyc();
      rst = 1; cyc();
      idle(); set_slot(0, 1, 1, 1, 0, 0); set_slot(1, 1, 1, 2, 0, 0); cyc();
      // Head wrap: single retires up to 15, then two.
      idle(); rst = 1; cyc();
      idle(); set_slot(0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 15; i++) cyc();
      set_slot(1, 1, 1, 2, 0, 0); cyc();
      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         idle();
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < W; i++) begin
            hd_valid[i]   = ($urandom_range(0, 9) != 0);
            hd_rd_en[i]   = ($urandom_range(0, 4) != 0);
            hd_rdl[i*LW +: LW] = LW'($urandom_range(0, 3));
            hd_rdp[i*PW +: PW] = PW'($urandom);
            hd_rdps[i*PW +: PW] = ($urandom_range(0, 3) != 0) ? hd_rdp[i*PW +: PW]
                                  : hd_rdp[i*PW +: PW] ^ PW'($urandom_range(1, 63));
            hd_memwen[i]  = ($urandom_range(0, 3) == 0);
            hd_mispred[i] = ($urandom_range(0, 9) == 0);
         end
         for (int j = 0; j < RN; j++) begin
            rn_rd_en[j] = $urandom_range(0, 1) == 1;
            rn_rdl[j*LW +: LW] = LW'($urandom_range(0, 7));
         end
         sb_ready = ($urandom_range(0, 9) < 7);
         cyc();
      end
      idle();
      @(posedge clk);
      #2;
      chk("scoreboard_drain", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
